pipeline_sequencer: RTL
=======================

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 Parameter WAIT_TIMEOUT, default 15: maximum consecutive data-memory wait cycles tolerated.
REQ-002 Parameter CNT_W, default 16: width of the performance counters.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 IFID_Rs, IFID_Rt  input  5 each  source registers of the instruction in IF/ID.
REQ-006 IDEX_Rt  input  5  destination register of the load in ID/EX.
REQ-007 IDEX_MemRead  input  1  ID/EX instruction is a load.
REQ-008 EXMEM_redirect  input  1  taken branch, jump or jr resolved in EX/MEM; the PC mux selects the target this cycle.
REQ-009 mem_req  input  1  EX/MEM instruction accesses data memory (MemRead or MemWrite).
REQ-010 mem_ready  input  1  data memory completes the access this cycle.
REQ-011 PC_write, IFID_write  output  1 each  enables for the PC and IF/ID registers.
REQ-012 pipe_enable  output  1  enable for the ID/EX, EX/MEM and MEM/WB registers.
REQ-013 IFID_flush, IDEX_nop, EXMEM_flush  output  1 each  load a bubble into the named register.
REQ-014 ctrl_state  output  2  current FSM state encoding.
REQ-015 timeout_err  output  1  sticky memory-timeout flag.
REQ-016 stall_count, flush_count  output  CNT_W each  saturating performance counters.

Function
REQ-017 The FSM SHALL have three states: RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2; 2'd3 SHALL be treated as HALT.
REQ-018 Define load_use = IDEX_MemRead & (IDEX_Rt != 0) & (IDEX_Rt == IFID_Rs | IDEX_Rt == IFID_Rt).
REQ-019 Define mem_wait = mem_req & ~mem_ready.
REQ-020 Priority in RUN: mem_wait, then EXMEM_redirect, then load_use.
REQ-021 RUN with no event: PC_write, IFID_write and pipe_enable SHALL be 1, and every flush output SHALL be 0.
REQ-022 RUN with mem_wait: PC_write, IFID_write and pipe_enable SHALL be 0 in the same cycle, and the next state SHALL be MEM_WAIT.
REQ-023 RUN with EXMEM_redirect and no mem_wait: all enables SHALL be 1, IFID_flush, IDEX_nop and EXMEM_flush SHALL be 1, and flush_count SHALL increment.
REQ-024 RUN with load_use only: PC_write and IFID_write SHALL be 0, IDEX_nop SHALL be 1, pipe_enable SHALL be 1, stall_count SHALL increment, and the state SHALL stay RUN (exactly one bubble per hazard).
REQ-025 MEM_WAIT: all enables SHALL be 0 and all flushes SHALL be 0.
REQ-026 MEM_WAIT uses a wait counter that SHALL clear on entry and increment each cycle mem_ready is 0; stall_count SHALL increment every MEM_WAIT cycle.
REQ-027 MEM_WAIT with mem_ready=1: the sequencer SHALL return to RUN the next cycle, and that cycle is evaluated fresh under REQ-020.
REQ-028 MEM_WAIT with the wait counter reaching WAIT_TIMEOUT while mem_ready=0: the next state SHALL be HALT and timeout_err SHALL be set.
REQ-029 HALT: all enables SHALL be 0 and all flushes SHALL be 0 until reset; timeout_err SHALL remain 1.
REQ-030 Both counters SHALL saturate at all-ones and never wrap.
REQ-031 Outputs are combinational from the state and the current inputs; the state, the counters and timeout_err are registered.

Reset
REQ-032 While reset=0: state=RUN, wait counter=0, stall_count=0, flush_count=0, timeout_err=0, and all enables and flushes SHALL be forced to 0.
REQ-033 Reset asserted mid-MEM_WAIT or in HALT SHALL return the sequencer to RUN asynchronously.
REQ-034 After reset deasserts, the first clock edge SHALL operate as RUN.

Structure
REQ-035 The state encodings and the default WAIT_TIMEOUT SHALL reside in the shared processor package.
REQ-036 One sub-module, sat_counter (parameterized width, inc input, saturating), SHALL be instantiated twice for the performance counters.
REQ-037 The existing combinational hazard unit and Control_nop select SHALL be driven by this block; the hazard logic SHALL NOT be duplicated elsewhere.

Verification
REQ-038 Load-use test: IDEX_MemRead=1, IDEX_Rt=5, IFID_Rs=5 for one cycle -> PC_write=0, IFID_write=0, IDEX_nop=1 for exactly one cycle; stall_count=1.
REQ-039 Redirect test: EXMEM_redirect=1 together with the load_use condition -> three flushes=1, PC_write=1, IDEX_nop=1, stall_count unchanged, flush_count=1.
REQ-040 Memory-wait test: mem_req=1 with mem_ready=0 for 3 cycles, then mem_ready=1 -> pipe_enable=0 for 4 cycles, ctrl_state=1 during the wait, then RUN; stall_count=3.
REQ-041 Timeout test: mem_req=1 with mem_ready held at 0 and WAIT_TIMEOUT=15 -> ctrl_state=2 and timeout_err=1 after 16 cycles; the condition persists until reset=0.
REQ-042 Saturation test: CNT_W=4 with 20 load-use stalls -> stall_count=4'hF.
REQ-043 Async reset test: reset=0 asserted between clock edges during MEM_WAIT -> ctrl_state=0 and all outputs 0 immediately.

Source files
------------

// File: rtl/pipeline_sequencer_pkg.sv
// Shared processor definitions: sequencer state encodings and timeout default.
package pipeline_sequencer_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } seq_state_t;

    localparam int unsigned DEFAULT_WAIT_TIMEOUT = 15;

endpackage

// File: rtl/pipeline_sequencer_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Count up on request; hold once all-ones is reached.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: load-use hazard detection, redirect flushing,
// data-memory wait stalling with timeout, and stall/flush statistics.
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = DEFAULT_WAIT_TIMEOUT,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IFID_Rs,
    input  logic [4:0]       IFID_Rt,
    input  logic [4:0]       IDEX_Rt,
    input  logic             IDEX_MemRead,
    input  logic             EXMEM_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             PC_write,
    output logic             IFID_write,
    output logic             pipe_enable,
    output logic             IFID_flush,
    output logic             IDEX_nop,
    output logic             EXMEM_flush,
    output logic [1:0]       ctrl_state,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned           WT_W     = $clog2(WAIT_TIMEOUT + 2);
    localparam logic [WT_W-1:0]       WT_LIMIT = WT_W'(WAIT_TIMEOUT);

    seq_state_t      r_state;
    seq_state_t      w_next_state;
    logic [WT_W-1:0] r_wait_cnt;
    logic [WT_W-1:0] w_wait_cnt_nxt;
    logic            r_timeout_err;
    logic            w_set_timeout;
    logic            w_stall_inc;
    logic            w_flush_inc;
    logic            w_load_use;
    logic            w_mem_wait;

    assign w_load_use = IDEX_MemRead & (IDEX_Rt != 5'd0) &
                        ((IDEX_Rt == IFID_Rs) | (IDEX_Rt == IFID_Rt));
    assign w_mem_wait = mem_req & ~mem_ready;

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_timeout_err <= r_timeout_err | w_set_timeout;
        end
    end

    // Next-state and pipeline control; everything forced low while in reset.
    always_comb begin
        w_next_state   = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_set_timeout  = 1'b0;
        w_stall_inc    = 1'b0;
        w_flush_inc    = 1'b0;
        PC_write       = 1'b0;
        IFID_write     = 1'b0;
        pipe_enable    = 1'b0;
        IFID_flush     = 1'b0;
        IDEX_nop       = 1'b0;
        EXMEM_flush    = 1'b0;

        case (r_state)
            RUN: begin
                if (w_mem_wait) begin
                    w_next_state   = MEM_WAIT;
                    w_wait_cnt_nxt = '0;
                end else begin
                    PC_write    = 1'b1;
                    IFID_write  = 1'b1;
                    pipe_enable = 1'b1;
                    if (EXMEM_redirect) begin
                        IFID_flush  = 1'b1;
                        IDEX_nop    = 1'b1;
                        EXMEM_flush = 1'b1;
                        w_flush_inc = 1'b1;
                    end else if (w_load_use) begin
                        PC_write    = 1'b0;
                        IFID_write  = 1'b0;
                        IDEX_nop    = 1'b1;
                        w_stall_inc = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                w_stall_inc = 1'b1;
                if (mem_ready) begin
                    w_next_state = RUN;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                    if (w_wait_cnt_nxt == WT_LIMIT) begin
                        w_next_state  = HALT;
                        w_set_timeout = 1'b1;
                    end
                end
            end
            default: begin
                // HALT, and the unused encoding 2'd3, lock until reset.
                w_next_state = HALT;
            end
        endcase

        if (!reset) begin
            w_stall_inc = 1'b0;
            w_flush_inc = 1'b0;
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            pipe_enable = 1'b0;
            IFID_flush  = 1'b0;
            IDEX_nop    = 1'b0;
            EXMEM_flush = 1'b0;
        end
    end

    assign ctrl_state  = r_state;
    assign timeout_err = r_timeout_err;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_inc   (w_stall_inc),
        .o_count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_inc   (w_flush_inc),
        .o_count (flush_count)
    );

endmodule
